// File: rtl/imem_preload_ctrl.sv
// Instruction-SRAM preload controller: streams a program image into SRAM, optionally reads it
// back against a running checksum, and holds the core in reset until the image is good.
module imem_preload_ctrl #(
  parameter int unsigned INST_W    = 32,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned CNT_W     = 16,
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              verify_req,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [INST_W-1:0] s_data,
  output logic              inst_sram_wen,
  output logic [ADDR_W-1:0] inst_sram_waddr,
  output logic [INST_W-1:0] inst_sram_wdata,
  output logic [ADDR_W-1:0] inst_sram_raddr,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic              inst_sram_en_toif,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [INST_W-1:0] checksum,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam int unsigned AW1 = ADDR_W + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StVerify,
    StRun,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  count_q;
  logic              verify_q;
  logic [CNT_W-1:0]  idx_q;
  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [INST_W-1:0] wdata_q;
  logic [INST_W-1:0] checksum_q;
  logic [CNT_W-1:0]  words_loaded_q;

  logic [ADDR_W-1:0] raddr_q;
  logic [CNT_W-1:0]  rd_idx_q;
  logic              rd_done_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic              cmp_q;
  logic [INST_W-1:0] vsum_q;

  logic [AW1-1:0]    end_addr;
  logic              cfg_bad;
  logic              start_accept;
  logic              accept;
  logic              load_last;
  logic              rd_issue;
  logic              rd_last;
  logic              verify_sel;

  // Bounds check is done one bit wider than the address so a huge base cannot wrap past it.
  assign end_addr     = {1'b0, base_addr} + AW1'(word_count);
  assign cfg_bad      = (word_count == '0) || (end_addr > AW1'(DEPTH));
  assign start_accept = start_load &&
                        ((state_q == StIdle) || (state_q == StRun) || (state_q == StErr));
  assign accept       = (state_q == StLoad) && s_valid;
  assign load_last    = (idx_q == count_q - CNT_W'(1));
  assign rd_issue     = (state_q == StVerify) && !rd_done_q;
  assign rd_last      = (rd_idx_q == count_q - CNT_W'(1));
  assign verify_sel   = VERIFY_EN && verify_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    s_ready           = 1'b0;
    inst_sram_en_toif = 1'b0;
    cpu_reset         = 1'b1;
    busy              = 1'b0;
    done              = 1'b0;
    error             = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_accept) state_d = cfg_bad ? StErr : StLoad;
      end
      StLoad: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (accept && load_last) state_d = StDrain;
      end
      StDrain: begin
        busy    = 1'b1;
        state_d = verify_sel ? StVerify : StRun;
      end
      StVerify: begin
        busy = 1'b1;
        if (cmp_q) state_d = (vsum_q == checksum_q) ? StRun : StErr;
      end
      StRun: begin
        inst_sram_en_toif = 1'b1;
        cpu_reset         = 1'b0;
        done              = 1'b1;
        if (start_accept) state_d = cfg_bad ? StErr : StLoad;
      end
      StErr: begin
        error = 1'b1;
        if (start_accept) state_d = cfg_bad ? StErr : StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q         <= '0;
      count_q        <= '0;
      verify_q       <= 1'b0;
      idx_q          <= '0;
      wen_q          <= 1'b0;
      waddr_q        <= '0;
      wdata_q        <= '0;
      checksum_q     <= '0;
      words_loaded_q <= '0;
      raddr_q        <= '0;
      rd_idx_q       <= '0;
      rd_done_q      <= 1'b0;
      rvalid_q       <= 1'b0;
      rlast_q        <= 1'b0;
      cmp_q          <= 1'b0;
      vsum_q         <= '0;
    end else begin
      wen_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      cmp_q    <= rvalid_q && rlast_q;

      if (start_accept) begin
        base_q   <= base_addr;
        count_q  <= word_count;
        verify_q <= verify_req;
        idx_q    <= '0;
        if (!cfg_bad) begin
          checksum_q     <= '0;
          words_loaded_q <= '0;
        end
      end

      if (accept) begin
        wen_q          <= 1'b1;
        waddr_q        <= base_q + ADDR_W'(idx_q);
        wdata_q        <= s_data;
        checksum_q     <= checksum_q + s_data;
        words_loaded_q <= words_loaded_q + CNT_W'(1);
        idx_q          <= idx_q + CNT_W'(1);
      end

      if (state_q == StDrain) begin
        raddr_q   <= base_q;
        rd_idx_q  <= '0;
        rd_done_q <= 1'b0;
        vsum_q    <= '0;
      end

      // Read address leads the accumulated data by the SRAM's one-cycle latency.
      if (rd_issue) begin
        rvalid_q <= 1'b1;
        rlast_q  <= rd_last;
        if (rd_last) begin
          rd_done_q <= 1'b1;
        end else begin
          raddr_q  <= raddr_q + ADDR_W'(1);
          rd_idx_q <= rd_idx_q + CNT_W'(1);
        end
      end

      if (rvalid_q) vsum_q <= vsum_q + inst_sram_rdata;
    end
  end

  assign inst_sram_wen   = wen_q;
  assign inst_sram_waddr = waddr_q;
  assign inst_sram_wdata = wdata_q;
  assign inst_sram_raddr = raddr_q;
  assign checksum        = checksum_q;
  assign words_loaded    = words_loaded_q;

endmodule

// File: tb/tb_imem_preload_ctrl.sv
// Self-checking bench for imem_preload_ctrl: directed and randomized loads against a
// transaction-level model of writes, checksum and final outcome.
module tb_imem_preload_ctrl;
  localparam int unsigned INST_W = 32;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_load;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              verify_req;
  logic              s_valid;
  logic              s_ready;
  logic [INST_W-1:0] s_data;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [INST_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr;
  logic [INST_W-1:0] rdata;
  logic              en_toif;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [INST_W-1:0] checksum;
  logic [CNT_W-1:0]  words_loaded;

  always #5 clk = ~clk;

  imem_preload_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .start_load        (start_load),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .verify_req        (verify_req),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .inst_sram_wen     (wen),
    .inst_sram_waddr   (waddr),
    .inst_sram_wdata   (wdata),
    .inst_sram_raddr   (raddr),
    .inst_sram_rdata   (rdata),
    .inst_sram_en_toif (en_toif),
    .cpu_reset         (cpu_reset),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .checksum          (checksum),
    .words_loaded      (words_loaded)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  int          wen_seen = 0;

  typedef struct {
    int unsigned cyc;
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wq[$];
  logic [31:0] mem [0:1023];
  logic [31:0] img [0:63];
  bit          flip_en;
  logic [63:0] flip_addr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model with one-cycle read latency and an optional single-bit readback fault.
  always @(posedge clk) begin
    if (wen) mem[waddr[9:0]] <= wdata;
    rdata <= mem[raddr[9:0]] ^ ((flip_en && raddr == flip_addr) ? 32'h0000_0008 : 32'h0);
  end

  always @(negedge clk) begin : mon
    wr_t e;
    if (wen === 1'b1) begin
      wen_seen++;
      if (exp_wq.size() == 0) begin
        check_eq("wen_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_wq.pop_front();
        check_eq("wen_cycle", 64'(cyc), 64'(e.cyc));
        check_eq("waddr", waddr, e.addr);
        check_eq("wdata", 64'(wdata), 64'(e.data));
      end
    end
  end

  // mode: 0 = valid always, 1 = valid pattern 1,0,0,..., 2 = random stalls
  task automatic run_load(input logic [63:0] base, input int n, input bit vreq, input int mode,
                          input bit poke_mid);
    logic [31:0] sum;
    logic [64:0] endv;
    bit          bad;
    bit          exp_err;
    bit          v;
    bit          poked;
    int          k;
    int          j;
    int          w0;
    int unsigned last_cyc;
    sum = '0;
    for (int i = 0; i < n; i++) sum = sum + img[i];
    endv    = {1'b0, base} + 65'(n);
    bad     = (n == 0) || (endv > 65'(DEPTH));
    exp_err = vreq && flip_en && (flip_addr >= base) && (flip_addr < base + 64'(n));
    w0      = wen_seen;
    poked   = 1'b0;
    last_cyc = 0;

    @(negedge clk);
    base_addr  = base;
    word_count = 16'(n);
    verify_req = vreq;
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;

    if (bad) begin
      check_eq("cfg_error", 64'(error), 64'(1));
      check_eq("cfg_busy", 64'(busy), 64'(0));
      check_eq("cfg_cpu_reset", 64'(cpu_reset), 64'(1));
      check_eq("cfg_done", 64'(done), 64'(0));
      repeat (3) @(negedge clk);
      check_eq("cfg_no_wen", 64'(wen_seen), 64'(w0));
      return;
    end

    check_eq("ld_busy", 64'(busy), 64'(1));
    check_eq("ld_cpu_reset", 64'(cpu_reset), 64'(1));
    check_eq("ld_en_toif", 64'(en_toif), 64'(0));
    check_eq("ld_error", 64'(error), 64'(0));
    check_eq("ld_done", 64'(done), 64'(0));
    check_eq("ld_clr_checksum", 64'(checksum), 64'(0));
    check_eq("ld_clr_count", 64'(words_loaded), 64'(0));

    k = 0;
    j = 0;
    while (k < n && j < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (j % 3 == 0);
        default: v = ($urandom_range(0, 99) >= 40);
      endcase
      s_valid = v;
      s_data  = v ? img[k] : $urandom;
      if (v && s_ready) begin
        exp_wq.push_back('{cyc + 1, base + 64'(k), img[k]});
        k++;
        last_cyc = cyc + 1;
      end
      if (poke_mid && k >= 1 && !poked) begin
        // A start pulse with a different config mid-load must be ignored.
        start_load = 1'b1;
        base_addr  = base + 64'd100;
        word_count = 16'd1;
        poked      = 1'b1;
      end else begin
        start_load = 1'b0;
      end
      j++;
      @(negedge clk);
    end
    s_valid    = 1'b0;
    start_load = 1'b0;
    check_eq("load_words_accepted", 64'(k), 64'(n));
    check_eq("s_ready_drop", 64'(s_ready), 64'(0));

    j = 0;
    while (!(done || error) && j < 200) begin
      @(negedge clk);
      j++;
    end
    check_eq("outcome_reached", 64'(done || error), 64'(1));
    if (!vreq) check_eq("run_latency", 64'(cyc), 64'(last_cyc + 1));
    check_eq("writes_all_seen", 64'(exp_wq.size()), 64'(0));
    check_eq("checksum", 64'(checksum), 64'(sum));
    check_eq("words_loaded", 64'(words_loaded), 64'(n));
    check_eq("done", 64'(done), 64'(!exp_err));
    check_eq("error", 64'(error), 64'(exp_err));
    check_eq("cpu_reset", 64'(cpu_reset), 64'(exp_err));
    check_eq("en_toif", 64'(en_toif), 64'(!exp_err));
    check_eq("busy_end", 64'(busy), 64'(0));
    if (vreq && !exp_err) check_eq("raddr_last", raddr, base + 64'(n) - 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(1));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
    check_eq({tag, "_error"}, 64'(error), 64'(0));
    check_eq({tag, "_en_toif"}, 64'(en_toif), 64'(0));
    check_eq({tag, "_wen"}, 64'(wen), 64'(0));
    check_eq({tag, "_s_ready"}, 64'(s_ready), 64'(0));
    check_eq({tag, "_checksum"}, 64'(checksum), 64'(0));
    check_eq({tag, "_words_loaded"}, 64'(words_loaded), 64'(0));
  endtask

  initial begin
    int          n;
    int          sel;
    logic [63:0] b;
    bit          vr;

    reset      = 1'b0;
    start_load = 1'b0;
    base_addr  = '0;
    word_count = '0;
    verify_req = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    flip_en    = 1'b0;
    flip_addr  = '0;

    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    check_eq("rst_raddr", raddr, 64'(0));
    check_eq("rst_waddr", waddr, 64'(0));
    check_eq("rst_wdata", 64'(wdata), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    img[0] = 32'h0140_0113;
    img[1] = 32'h0051_0193;
    img[2] = 32'h0010_0A13;
    img[3] = 32'h003A_30A3;

    run_load(64'd1, 4, 1'b0, 0, 1'b0);
    check_eq("tp_checksum", 64'(checksum), 64'h01DB_3D5C);
    run_load(64'd1, 4, 1'b1, 0, 1'b0);

    flip_en   = 1'b1;
    flip_addr = 64'd3;
    run_load(64'd1, 4, 1'b1, 0, 1'b0);
    flip_addr = 64'd5;
    run_load(64'd1, 4, 1'b1, 0, 1'b0);
    flip_en   = 1'b0;

    run_load(64'd1, 4, 1'b0, 1, 1'b0);
    check_eq("stall_checksum", 64'(checksum), 64'h01DB_3D5C);

    run_load(64'd1, 0, 1'b0, 0, 1'b0);
    run_load(64'd1020, 5, 1'b0, 0, 1'b0);
    run_load(64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0, 0, 1'b0);
    run_load(64'd1020, 4, 1'b1, 0, 1'b0);

    // Reset after two of four words have been accepted.
    @(negedge clk);
    base_addr  = 64'd10;
    word_count = 16'd4;
    verify_req = 1'b0;
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("mid_s_ready", 64'(s_ready), 64'(1));
      s_valid = 1'b1;
      s_data  = img[i];
      exp_wq.push_back('{cyc + 1, 64'(10 + i), img[i]});
      @(negedge clk);
    end
    check_eq("mid_words_loaded", 64'(words_loaded), 64'(2));
    s_valid = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_rst");
    reset = 1'b1;
    check_eq("mid_rst_writes", 64'(exp_wq.size()), 64'(0));

    run_load(64'd10, 4, 1'b0, 0, 1'b0);
    run_load(64'd200, 4, 1'b0, 2, 1'b1);

    for (int it = 0; it < 25; it++) begin
      n   = $urandom_range(1, 12);
      sel = $urandom_range(0, 5);
      case (sel)
        0:       b = 64'(DEPTH - n);
        1:       b = 64'(DEPTH - n + 1);
        2:       n = 0;
        default: b = 64'($urandom_range(0, DEPTH - 1));
      endcase
      if (sel == 2) b = 64'($urandom_range(0, DEPTH - 1));
      for (int i = 0; i < 12; i++) img[i] = $urandom;
      vr        = ($urandom_range(0, 1) == 1);
      flip_en   = vr && ($urandom_range(0, 2) == 0);
      flip_addr = b + 64'($urandom_range(0, 12));
      run_load(b, n, vr, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end
    flip_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_preload_ctrl.md
Name: imem_preload_ctrl

Overview:
- Parametrised instruction-SRAM preload controller. It accepts a program as a valid/ready word stream and writes it into instruction SRAM at consecutive word addresses from a base.
- Optionally reads the image back and checks it against a running checksum.
- Holds the CPU core in reset until the image is loaded and verified, then releases the core and enables instruction fetch.
- Sits between the bench/host loader and mycpu_top's inst_sram preload port and reset input.

Parameters:
INST_W, 32, instruction word width in bits
ADDR_W, 64, SRAM word-address width
DEPTH, 1024, SRAM depth in words (valid addresses 0..DEPTH-1)
CNT_W, 16, width of the word-count field
VERIFY_EN, 1, 1 = readback-verify logic is present; 0 = verify request ignored

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start_load  in  1  one-cycle pulse: latch base_addr/word_count/verify_req and begin a load
base_addr  in  ADDR_W  first SRAM word address
word_count  in  CNT_W  number of words to load
verify_req  in  1  request readback verify after the load
s_valid  in  1  stream word valid
s_ready  out  1  controller accepts a stream word
s_data  in  INST_W  stream word
inst_sram_wen  out  1  SRAM write enable
inst_sram_waddr  out  ADDR_W  SRAM write address
inst_sram_wdata  out  INST_W  SRAM write data
inst_sram_raddr  out  ADDR_W  SRAM readback address
inst_sram_rdata  in  INST_W  SRAM readback data (1-cycle read latency)
inst_sram_en_toif  out  1  enables instruction fetch
cpu_reset  out  1  active-high reset to the core
busy  out  1  load or verify in progress
done  out  1  image loaded (and verified if requested); core running
error  out  1  config error or verify mismatch
checksum  out  INST_W  modulo-2^INST_W sum of all accepted words
words_loaded  out  CNT_W  count of accepted words

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; cpu_reset=1; all other outputs 0; counters and checksum cleared. Reset asserted mid-load or mid-verify aborts the operation. SRAM contents are left undefined.
- States: IDLE, LOAD, DRAIN, VERIFY, RUN, ERR.
- start_load in IDLE, RUN or ERR:
  - Check the latched config. word_count==0 or base_addr+word_count>DEPTH, evaluated without wrap in ADDR_W+1 bits: go to ERR, error=1.
  - Otherwise go to LOAD. Clear checksum and words_loaded; cpu_reset=1; en_toif=0; busy=1; done=0; error=0.
- start_load while in LOAD, DRAIN or VERIFY is ignored.
- LOAD:
  - s_ready=1. Each s_valid&&s_ready cycle accepts s_data.
  - Next cycle: wen=1, waddr=base_addr+index, wdata=word. Write outputs are registered, so latency is 1 cycle.
  - checksum and words_loaded update in the same next cycle.
  - s_ready drops the cycle after the last word (index==word_count-1) is accepted. Then go to DRAIN.
  - s_valid low stalls without timeout.
- DRAIN: exactly one cycle; the last write completes here. Next state: VERIFY if VERIFY_EN&&verify_req, else RUN.
- VERIFY:
  - raddr steps base..base+word_count-1, one per cycle.
  - rdata is sampled the cycle after each raddr and accumulated into a separate sum.
  - One cycle after the final rdata, compare with checksum: equal goes to RUN, unequal goes to ERR (error=1).
- RUN: cpu_reset=0, inst_sram_en_toif=1, done=1, busy=0. Stays until start_load or reset.
- ERR: cpu_reset=1, en_toif=0, error=1, busy=0. Stays until a valid start_load or reset.
- inst_sram_wen=0 in every state except the write cycle following a handshake.
- Address arithmetic is ADDR_W bits. Wrap is impossible because of the start check.

Test Plan:
- Load 4 words 0x01400113, 0x00510193, 0x00100A13, 0x003A30A3 at base 1, verify_req=0, s_valid held high. Required: wen pulses at addresses 1..4 on consecutive cycles, each one cycle after acceptance; checksum=0x01DB3D5C; words_loaded=4; cpu_reset falls and en_toif/done rise 1 cycle after DRAIN.
- Same load with verify_req=1 and SRAM model echoing writes. Required: raddr 1..4; RUN reached, error=0. Then inject a single-bit flip at address 3: required ERR, error=1, cpu_reset stays 1.
- Stall: s_valid toggles 1,0,0,1,… Required: no wen on stall cycles, addresses stay consecutive, final checksum unchanged.
- Config errors: word_count=0 → ERR; base=1020, count=5, DEPTH=1024 → ERR. In both cases no wen is ever asserted.
- Reset (reset=0) after 2 of 4 words accepted: required IDLE next cycle, cpu_reset=1, outputs 0, words_loaded=0. A following start_load loads normally.
- start_load while in RUN: cpu_reset reasserts next cycle and a full reload completes. start_load pulsed during LOAD is ignored.
